// File: rtl/cpu_clock_enable_ctrl_pkg.sv
// Shared state encoding and default sizing for the CPU clock-enable controller.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    PAUSE = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    HALT  = 2'b11
  } cpu_state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEFAULT_CNT_W           = 32;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_clock_enable_ctrl_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each accepted press.
module button_debouncer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic fast_clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int unsigned    CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_meta;
  logic          btn_s;
  logic          btn_stable;
  logic          btn_prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      btn_meta   <= 1'b0;
      btn_s      <= 1'b0;
      btn_stable <= 1'b0;
      btn_prev   <= 1'b0;
      cnt        <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_s    <= btn_meta;
      btn_prev <= btn_stable;
      // Any return to the accepted level restarts the stability window.
      if (btn_s == btn_stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        btn_stable <= btn_s;
        cnt        <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign btn_pulse = btn_stable & ~btn_prev;

endmodule

// File: rtl/cpu_clock_enable_ctrl.sv
// Turns the divider's slow_clk into a single-cycle CPU enable on fast_clk,
// with run/pause/single-step control and a CPU-driven halt latch.
module cpu_clock_enable_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic             fast_clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_ce,
  output logic             halted,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] cycle_count
);

  cpu_state_t state;
  cpu_state_t next_state;

  logic slow_meta;
  logic slow_s;
  logic slow_prev;
  logic run_meta;
  logic run_sw_s;
  logic tick;
  logic step_req;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .fast_clk (fast_clk),
    .rst      (rst),
    .btn_raw  (step_btn),
    .btn_pulse(step_req)
  );

  // slow_clk is treated purely as data; its rising edge becomes tick.
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      slow_meta <= 1'b0;
      slow_s    <= 1'b0;
      slow_prev <= 1'b0;
      run_meta  <= 1'b0;
      run_sw_s  <= 1'b0;
    end else begin
      slow_meta <= slow_clk;
      slow_s    <= slow_meta;
      slow_prev <= slow_s;
      run_meta  <= run_sw;
      run_sw_s  <= run_meta;
    end
  end

  assign tick = slow_s & ~slow_prev;

  always_comb begin
    next_state = state;
    case (state)
      PAUSE: begin
        if (run_sw_s)      next_state = RUN;
        else if (step_req) next_state = STEP;
      end
      RUN:  if (!run_sw_s) next_state = PAUSE;
      STEP: if (tick)      next_state = PAUSE;
      HALT: if (!run_sw_s) next_state = PAUSE;
      default:             next_state = PAUSE;
    endcase
    if (halt_req) next_state = HALT;
  end

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      state       <= PAUSE;
      cpu_ce      <= 1'b0;
      halted      <= 1'b0;
      cycle_count <= '0;
    end else begin
      state  <= next_state;
      cpu_ce <= tick & ((state == RUN) | (state == STEP)) & ~halt_req;
      halted <= (next_state == HALT);
      if (cpu_ce && (cycle_count != '1)) cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  assign mode = state;

endmodule
